// File: rtl/aska_stim_ctrl.sv
// ASKA stimulator core: SPI-configured biphasic, ramped, ON/OFF-gated
// current pulse generator driving the H-bridge switches and current DAC.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | enable low; outputs 0, period counters held at 0
// ST_ON   | pulsing; per_idx is the ramp period index k (1-based)
// ST_OFF  | silent gap between ON bursts; per_idx counts OFF periods
module aska_stim_ctrl #(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        porborn,
  input  logic        SPI_CS,
  input  logic        SPI_Clk,
  input  logic        SPI_MOSI,
  output logic [31:0] up_switches,
  output logic [31:0] down_switches,
  output logic [5:0]  DAC,
  output logic        pulse_active
);

  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} state_t;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic        clr;
  logic [1:0]  cs_sync, sck_sync, mosi_sync;
  logic        cs_prev, sck_prev;
  logic        cs_rise, sck_rise;
  logic [5:0]  bit_cnt;
  logic [39:0] shreg;
  logic        wr_en;
  logic [31:0] conf0, conf1, ele1, ele2;
  logic [TW-1:0] tick_cnt;
  logic        tick;

  state_t      state, state_nxt;
  logic [11:0] per_cnt, cnt_nxt;
  logic [9:0]  per_idx, idx_nxt;
  logic [31:0] up_nxt, down_nxt;
  logic [5:0]  dac_nxt;
  logic        pa_nxt;

  logic [11:0] freq, freq_last;
  logic [5:0]  amplitude, ramp, amp_sat, amp_k;
  logic [7:0]  on_time;
  logic [9:0]  ramp_factor, off_time;
  logic        enable;
  logic [2:0]  phase;
  logic [17:0] prod;
  logic [13:0] ramped;
  logic        period_end;
  logic        unused_bits;

  // reset and brown-out have identical effect
  assign clr = reset | ~porborn;

  assign freq        = conf0[11:0];
  assign amplitude   = conf0[17:12];
  assign ramp        = conf0[23:18];
  assign on_time     = conf0[31:24];
  assign ramp_factor = conf1[9:0];
  assign off_time    = conf1[19:10];
  assign enable      = conf1[20];
  assign phase       = conf1[23:21];
  assign unused_bits = ^{conf1[31:24], prod[3:0]};

  // two-stage synchronizers plus edge-detect history for the SPI pins
  always_ff @(posedge clk) begin
    if (clr) begin
      cs_sync   <= 2'b11;
      cs_prev   <= 1'b1;
      sck_sync  <= 2'b00;
      sck_prev  <= 1'b0;
      mosi_sync <= 2'b00;
    end else begin
      cs_sync   <= {cs_sync[0], SPI_CS};
      cs_prev   <= cs_sync[1];
      sck_sync  <= {sck_sync[0], SPI_Clk};
      sck_prev  <= sck_sync[1];
      mosi_sync <= {mosi_sync[0], SPI_MOSI};
    end
  end

  assign cs_rise  = cs_sync[1] & ~cs_prev;
  assign sck_rise = sck_sync[1] & ~sck_prev;

  // shift in MOSI on SPI clock rises; count saturates so long frames stay invalid
  always_ff @(posedge clk) begin
    if (clr) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (cs_sync[1]) begin
      bit_cnt <= '0;
    end else if (sck_rise) begin
      shreg <= {shreg[38:0], mosi_sync[1]};
      if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
    end
  end

  assign wr_en = cs_rise && (bit_cnt == 6'd40) && (shreg[39:32] <= 8'd3);

  // register file write on a complete 40-bit frame to a valid address
  always_ff @(posedge clk) begin
    if (clr) begin
      conf0 <= '0;
      conf1 <= '0;
      ele1  <= '0;
      ele2  <= '0;
    end else if (wr_en) begin
      case (shreg[33:32])
        2'd0: conf0 <= shreg[31:0];
        2'd1: conf1 <= shreg[31:0];
        2'd2: ele1  <= shreg[31:0];
        default: ele2 <= shreg[31:0];
      endcase
    end
  end

  // timebase: down-counter, tick on terminal count
  always_ff @(posedge clk) begin
    if (clr)       tick_cnt <= '0;
    else if (tick) tick_cnt <= TW'(TICK_DIV - 1);
    else           tick_cnt <= tick_cnt - 1'b1;
  end

  assign tick = (tick_cnt == '0);

  assign freq_last  = (freq == 12'd0) ? 12'hFFF : freq - 12'd1;
  assign period_end = (per_cnt >= freq_last);

  assign amp_sat = (amplitude > 6'd50) ? 6'd50 : amplitude;
  assign prod    = {10'b0, idx_nxt[7:0]} * {8'b0, ramp_factor};
  assign ramped  = prod[17:4];

  // next state, period counters, ramp amplitude and switch pattern
  always_comb begin
    state_nxt = state;
    cnt_nxt   = per_cnt;
    idx_nxt   = per_idx;
    amp_k     = amp_sat;
    up_nxt    = '0;
    down_nxt  = '0;
    dac_nxt   = '0;
    pa_nxt    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (enable) begin
          cnt_nxt   = '0;
          idx_nxt   = 10'd1;
          state_nxt = (on_time == 8'd0) ? ST_OFF : ST_ON;
        end
      end
      ST_ON: begin
        if (period_end) begin
          cnt_nxt = '0;
          if (per_idx >= {2'b0, on_time}) begin
            idx_nxt   = 10'd1;
            state_nxt = (off_time != 10'd0 || on_time == 8'd0) ? ST_OFF : ST_ON;
          end else begin
            idx_nxt = per_idx + 10'd1;
          end
        end else begin
          cnt_nxt = per_cnt + 12'd1;
        end
      end
      default: begin
        if (period_end) begin
          cnt_nxt = '0;
          if (per_idx >= off_time) begin
            idx_nxt = 10'd1;
            if (on_time != 8'd0) state_nxt = ST_ON;
          end else begin
            idx_nxt = per_idx + 10'd1;
          end
        end else begin
          cnt_nxt = per_cnt + 12'd1;
        end
      end
    endcase

    if (!enable) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end

    if (ramp != 6'd0 && idx_nxt <= {4'b0, ramp} && ramped < {8'b0, amp_sat})
      amp_k = ramped[5:0];

    if (state_nxt == ST_ON && phase != 3'd0) begin
      if (cnt_nxt < {9'b0, phase}) begin
        up_nxt   = ele1;
        down_nxt = ele2;
        dac_nxt  = amp_k;
        pa_nxt   = 1'b1;
      end else if (cnt_nxt < {8'b0, phase, 1'b0}) begin
        up_nxt   = ele2;
        down_nxt = ele1;
        dac_nxt  = amp_k;
        pa_nxt   = 1'b1;
      end
    end
  end

  // state, counters and registered outputs advance only on ticks
  always_ff @(posedge clk) begin
    if (clr) begin
      state         <= ST_IDLE;
      per_cnt       <= '0;
      per_idx       <= '0;
      up_switches   <= '0;
      down_switches <= '0;
      DAC           <= '0;
      pulse_active  <= 1'b0;
    end else if (tick) begin
      state         <= state_nxt;
      per_cnt       <= cnt_nxt;
      per_idx       <= idx_nxt;
      up_switches   <= up_nxt;
      down_switches <= down_nxt;
      DAC           <= dac_nxt;
      pulse_active  <= pa_nxt;
    end
  end

endmodule

// File: tb/tb_aska_stim_ctrl.sv
// Bench for aska_stim_ctrl: register-write table plus pulse/ramp sequences.
module tb_aska_stim_ctrl;

  logic        clk = 1'b0;
  logic        reset, porborn;
  logic        SPI_CS, SPI_Clk, SPI_MOSI;
  logic [31:0] up_switches, down_switches;
  logic [5:0]  DAC;
  logic        pulse_active;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [31:0] E1 = 32'h0000_8000;
  localparam logic [31:0] E2 = 32'h0000_4000;

  aska_stim_ctrl #(.TICK_DIV(1)) dut (
    .clk(clk), .reset(reset), .porborn(porborn),
    .SPI_CS(SPI_CS), .SPI_Clk(SPI_Clk), .SPI_MOSI(SPI_MOSI),
    .up_switches(up_switches), .down_switches(down_switches),
    .DAC(DAC), .pulse_active(pulse_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          nbits;
    logic [31:0] c0, c1, e1, e2;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic spi_write(input logic [7:0] addr, input logic [31:0] data, input int nbits);
    logic [39:0] word;
    word = {addr, data};
    repeat (4) @(negedge clk);
    SPI_CS = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      SPI_MOSI = (i < 40) ? word[39-i] : 1'b0;
      repeat (4) @(negedge clk);
      SPI_Clk = 1'b1;
      repeat (4) @(negedge clk);
      SPI_Clk = 1'b0;
    end
    repeat (4) @(negedge clk);
    SPI_CS = 1'b1;
  endtask

  task automatic chk_out(input string tag, input int t, input int dac, input int ph);
    logic [31:0] eu, ed;
    logic [5:0]  edac;
    logic        epa;
    eu = '0; ed = '0; edac = '0; epa = 1'b0;
    if (dac != 0 && ph != 0) begin
      if (t < ph) begin
        eu = E1; ed = E2; edac = 6'(dac); epa = 1'b1;
      end else if (t < 2*ph) begin
        eu = E2; ed = E1; edac = 6'(dac); epa = 1'b1;
      end
    end
    chk($sformatf("%s t%0d up", tag, t), up_switches, eu);
    chk($sformatf("%s t%0d down", tag, t), down_switches, ed);
    chk($sformatf("%s t%0d dac", tag, t), {26'b0, DAC}, {26'b0, edac});
    chk($sformatf("%s t%0d pa", tag, t), {31'b0, pulse_active}, {31'b0, epa});
  endtask

  // one period of fr ticks; dac=0 means a silent period
  task automatic run_period(input string tag, input int dac, input bit full,
                            input int fr, input int ph);
    for (int t = 0; t < fr; t++) begin
      @(negedge clk);
      if (full || t == 0 || t == ph-1 || t == ph || t == 2*ph-1 || t == 2*ph)
        chk_out(tag, t, dac, ph);
    end
  endtask

  // after an enabling write: commit at the 3rd edge, first pulse tick at the 4th
  task automatic align_after_enable(input string tag);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, " pre-start pa"}, {31'b0, pulse_active}, 32'd0);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (pulse_active || up_switches != 0 || down_switches != 0 || DAC != 0) seen = 1'b1;
    end
    chk({tag, " quiet"}, {31'b0, seen}, 32'd0);
  endtask

  task automatic wait_pa(input string tag, input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (pulse_active) found = 1'b1;
    end
    chk({tag, " pulse seen"}, {31'b0, found}, 32'd1);
  endtask

  initial begin
    bit found;
    vecs[0] = '{8'd2, 32'h0000_8000, 40, 32'h0,          32'h0,          E1, 32'h0};
    vecs[1] = '{8'd3, 32'h0000_4000, 40, 32'h0,          32'h0,          E1, E2};
    vecs[2] = '{8'd0, 32'h32CB_2190, 40, 32'h32CB_2190, 32'h0,          E1, E2};
    vecs[3] = '{8'd1, 32'h0080_C810, 40, 32'h32CB_2190, 32'h0080_C810, E1, E2};
    vecs[4] = '{8'd1, 32'hFFFF_FFFF, 32, 32'h32CB_2190, 32'h0080_C810, E1, E2};
    vecs[5] = '{8'd5, 32'hDEAD_BEEF, 40, 32'h32CB_2190, 32'h0080_C810, E1, E2};
    vecs[6] = '{8'd1, 32'h0012_3456, 41, 32'h32CB_2190, 32'h0080_C810, E1, E2};
    vecs[7] = '{8'd0, 32'h1234_5678, 39, 32'h32CB_2190, 32'h0080_C810, E1, E2};

    reset = 1'b1; porborn = 1'b1;
    SPI_CS = 1'b1; SPI_Clk = 1'b0; SPI_MOSI = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset up", up_switches, 32'h0);
    chk("reset down", down_switches, 32'h0);
    chk("reset dac", {26'b0, DAC}, 32'h0);
    chk("reset pa", {31'b0, pulse_active}, 32'h0);
    chk("reset conf1", dut.conf1, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      spi_write(vecs[v].addr, vecs[v].data, vecs[v].nbits);
      repeat (6) @(negedge clk);
      chk($sformatf("vec%0d conf0", v), dut.conf0, vecs[v].c0);
      chk($sformatf("vec%0d conf1", v), dut.conf1, vecs[v].c1);
      chk($sformatf("vec%0d ele1", v), dut.ele1, vecs[v].e1);
      chk($sformatf("vec%0d ele2", v), dut.ele2, vecs[v].e2);
    end

    // burst 1: amplitude 50, ramp 50, factor 16 -> DAC = k
    spi_write(8'd1, 32'h0090_C810, 40);
    align_after_enable("burst1");
    run_period("b1 k1", 1, 1'b1, 400, 4);
    for (int k = 2; k <= 50; k++) run_period($sformatf("b1 k%0d", k), k, 1'b0, 400, 4);
    for (int k = 1; k <= 50; k++) run_period($sformatf("off k%0d", k), 0, 1'b0, 400, 4);
    run_period("b2 k1", 1, 1'b0, 400, 4);
    run_period("b2 k2", 2, 1'b0, 400, 4);

    // disable mid-ON
    spi_write(8'd1, 32'h0080_C810, 40);
    repeat (4) @(posedge clk);
    expect_quiet("disabled", 1000);

    // re-enable with amplitude 25, ramp 25
    spi_write(8'd0, 32'h3265_9190, 40);
    spi_write(8'd1, 32'h0090_C810, 40);
    align_after_enable("reramp");
    for (int k = 1; k <= 27; k++)
      run_period($sformatf("rr k%0d", k), (k < 25) ? k : 25, k == 1, 400, 4);

    // brown-out while pulsing
    wait_pa("pre-porborn", 1000, found);
    porborn = 1'b0;
    @(negedge clk);
    chk("porborn up", up_switches, 32'h0);
    chk("porborn pa", {31'b0, pulse_active}, 32'h0);
    chk("porborn dac", {26'b0, DAC}, 32'h0);
    chk("porborn conf0", dut.conf0, 32'h0);
    chk("porborn conf1", dut.conf1, 32'h0);
    chk("porborn ele1", dut.ele1, 32'h0);
    porborn = 1'b1;
    expect_quiet("post-porborn", 2000);

    // freq 6, phase 4, amplitude 20: phase 2 truncated to 2 ticks
    spi_write(8'd2, E1, 40);
    spi_write(8'd3, E2, 40);
    spi_write(8'd0, 32'h0301_4006, 40);
    spi_write(8'd1, 32'h0090_0000, 40);
    align_after_enable("trunc");
    for (int p = 0; p < 5; p++) run_period($sformatf("tr p%0d", p), 20, 1'b1, 6, 4);

    // amplitude 63 saturates to 50
    spi_write(8'd0, 32'h0303_F006, 40);
    repeat (4) @(posedge clk);
    wait_pa("sat", 50, found);
    chk("sat dac", {26'b0, DAC}, 32'd50);

    // phase 0: counters run, no pulses
    spi_write(8'd1, 32'h0010_0000, 40);
    repeat (4) @(posedge clk);
    expect_quiet("phase0", 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
